reaction_timer_multi: RTL and testbench

Parametrised multi-player reaction timer core. After a start pulse, it waits a pseudo-random delay, raises a stimulus, then times each player's stop press in milliseconds. It flags false starts and timeouts and reports the winner. It sits between the per-button debouncers and the BCD conversion/display path, and consumes only single-cycle, already-debounced ticks.

---
 rtl/reaction_timer_multi_if.sv | 31 +++
 rtl/reaction_timer_multi.sv | 205 ++++++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_multi_if.sv
// Control ticks in, round results out, between the button debouncers
// and the multi-player reaction timer core.
interface reaction_timer_multi_if #(
    parameter int PLAYERS = 2,
    parameter int COUNT_N = 14
);
    logic                       start_i;
    logic                       clear_i;
    logic [PLAYERS-1:0]         stop_i;
    logic [1:0]                 state_o;
    logic                       stim_o;
    logic [PLAYERS*COUNT_N-1:0] time_o;
    logic [PLAYERS-1:0]         stopped_o;
    logic [PLAYERS-1:0]         false_o;
    logic [PLAYERS-1:0]         timeout_o;
    logic [2:0]                 winner_o;
    logic                       winner_vld_o;
    logic [COUNT_N-1:0]         best_o;

    modport master (
        output start_i, clear_i, stop_i,
        input  state_o, stim_o, time_o, stopped_o, false_o,
        input  timeout_o, winner_o, winner_vld_o, best_o
    );

    modport slave (
        input  start_i, clear_i, stop_i,
        output state_o, stim_o, time_o, stopped_o, false_o,
        output timeout_o, winner_o, winner_vld_o, best_o
    );
endinterface

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random delay, stimulus, per-player ms times.
// Define REACTION_BEST_EN to keep a best-time-ever register on best_o.
module reaction_timer_multi #(
    parameter int PLAYERS      = 2,
    parameter int TICK_DIV     = 100000,
    parameter int COUNT_N      = 14,
    parameter int MAX_MS       = 9999,
    parameter int MIN_DELAY_MS = 2000,
    parameter int RANGE_BITS   = 11
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    reaction_timer_multi_if.slave bus
);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RANGE_BITS));
    localparam int MW    = (COUNT_N > DLY_W) ? COUNT_N : DLY_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               stim_q, stim_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [MW-1:0]      ms_q, ms_d;
    logic [MW-1:0]      delay_q, delay_d;
    logic [COUNT_N-1:0] time_q [PLAYERS];
    logic [COUNT_N-1:0] time_d [PLAYERS];
    logic [PLAYERS-1:0] stopped_q, stopped_d;
    logic [PLAYERS-1:0] false_q, false_d;
    logic [PLAYERS-1:0] tout_q, tout_d;

    logic               tick;
    logic [2:0]         win_idx;
    logic               win_any;
    logic [COUNT_N-1:0] win_t;

    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        delay_d   = delay_q;
        time_d    = time_q;
        stopped_d = stopped_q;
        false_d   = false_q;
        tout_d    = tout_q;
        tick      = (presc_q == PW'(TICK_DIV - 1));

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d   = S_WAIT;
                    delay_d   = MW'(MIN_DELAY_MS)
                              + MW'(lfsr_q[RANGE_BITS-1:0]);
                    time_d    = '{default: '0};
                    stopped_d = '0;
                    false_d   = '0;
                    tout_d    = '0;
                    presc_d   = '0;
                    ms_d      = '0;
                end
            end
            S_WAIT: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                ms_d    = tick ? ms_q + 1'b1 : ms_q;
                false_d = false_q | bus.stop_i;
                if (&false_d) begin
                    state_d = S_DONE;
                end else if (ms_q == delay_q) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    ms_d    = '0;
                end
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                ms_d    = tick ? ms_q + 1'b1 : ms_q;
                for (int i = 0; i < PLAYERS; i++) begin
                    if (bus.stop_i[i] && !false_q[i] && !stopped_q[i]) begin
                        time_d[i]    = ms_q[COUNT_N-1:0];
                        stopped_d[i] = 1'b1;
                    end
                end
                if (&(stopped_d | false_q)) begin
                    state_d = S_DONE;
                end else if (ms_q == MW'(MAX_MS)) begin
                    // a stop landing on the limit cycle stays a valid stop
                    state_d = S_DONE;
                    for (int i = 0; i < PLAYERS; i++) begin
                        if (!false_q[i] && !stopped_d[i]) begin
                            time_d[i] = COUNT_N'(MAX_MS);
                            tout_d[i] = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
            end
        endcase

        if (bus.clear_i) begin
            state_d   = S_IDLE;
            time_d    = '{default: '0};
            stopped_d = '0;
            false_d   = '0;
            tout_d    = '0;
            presc_d   = '0;
            ms_d      = '0;
        end

        stim_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            stim_q    <= 1'b0;
            lfsr_q    <= 16'hACE1;
            presc_q   <= '0;
            ms_q      <= '0;
            delay_q   <= '0;
            time_q    <= '{default: '0};
            stopped_q <= '0;
            false_q   <= '0;
            tout_q    <= '0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            lfsr_q    <= lfsr_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
            delay_q   <= delay_d;
            time_q    <= time_d;
            stopped_q <= stopped_d;
            false_q   <= false_d;
            tout_q    <= tout_d;
        end
    end

    // strict compare keeps ties on the lowest index
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        win_t   = '1;
        for (int i = 0; i < PLAYERS; i++) begin
            if (stopped_q[i] && (!win_any || time_q[i] < win_t)) begin
                win_idx = 3'(i);
                win_any = 1'b1;
                win_t   = time_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PLAYERS; i++) begin
            bus.time_o[i*COUNT_N +: COUNT_N] = time_q[i];
        end
    end

    assign bus.state_o      = state_q;
    assign bus.stim_o       = stim_q;
    assign bus.stopped_o    = stopped_q;
    assign bus.false_o      = false_q;
    assign bus.timeout_o    = tout_q;
    assign bus.winner_o     = (state_q == S_DONE) ? win_idx : 3'd0;
    assign bus.winner_vld_o = (state_q == S_DONE) && win_any;

`ifdef REACTION_BEST_EN
    logic               done_new_q, done_new_d;
    logic [COUNT_N-1:0] best_q, best_d;

    always_comb begin
        done_new_d = (state_d == S_DONE) && (state_q != S_DONE);
        best_d     = best_q;
        if (done_new_q && win_any && (win_t < best_q)) begin
            best_d = win_t;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            done_new_q <= 1'b0;
            best_q     <= '1;
        end else begin
            done_new_q <= done_new_d;
            best_q     <= best_d;
        end
    end

    assign bus.best_o = best_q;
`else
    assign bus.best_o = '1;
`endif

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi with a small-parameter build.
// Expected delays come from an independent model of the start-delay LFSR.
module tb_reaction_timer_multi;
    localparam int P    = 2;
    localparam int TD   = 4;
    localparam int CN   = 14;
    localparam int MX   = 20;
    localparam int MIND = 3;
    localparam int RB   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int run_at    = 0;
    int d         = 0;

    logic [15:0] m_lfsr;

    reaction_timer_multi_if #(.PLAYERS(P), .COUNT_N(CN)) bus ();

    reaction_timer_multi #(
        .PLAYERS     (P),
        .TICK_DIV    (TD),
        .COUNT_N     (CN),
        .MAX_MS      (MX),
        .MIN_DELAY_MS(MIND),
        .RANGE_BITS  (RB)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0],
                            m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end

    function automatic logic [27:0] pk(input int t1, input int t0);
        logic [13:0] a1, a0;
        a1 = 14'(t1);
        a0 = 14'(t0);
        return {a1, a0};
    endfunction

    function automatic logic [13:0] exp_best(input int v);
`ifdef REACTION_BEST_EN
        return 14'(v);
`else
        return 14'h3FFF;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_stop(input logic [1:0] m);
        bus.stop_i = m;
        step();
        bus.stop_i = '0;
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        chk("clear_state", bus.state_o, 2'd0);
        chk("clear_stopped", bus.stopped_o, 2'b00);
    endtask

    task automatic start_round();
        d = MIND + int'(m_lfsr[1:0]);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        start_cyc = cyc;
        chk("start_wait", bus.state_o, 2'd1);
        chk("stim_wait", bus.stim_o, 1'b0);
    endtask

    task automatic wait_run(input bit chk_len);
        int n;
        n = 0;
        while (bus.state_o != 2'd2 && n < 40) begin
            step();
            n++;
        end
        chk("reach_run", bus.state_o, 2'd2);
        chk("stim_run", bus.stim_o, 1'b1);
        if (chk_len)
            chk("wait_len", 64'((cyc - start_cyc) >= 4 * d &&
                                (cyc - start_cyc) <= 4 * d + 1), 64'd1);
        run_at = cyc;
    endtask

    task automatic to_ms(input int k);
        while (cyc < run_at + TD * k) step();
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.stop_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_state", bus.state_o, 2'd0);
        chk("rst_stim", bus.stim_o, 1'b0);
        chk("rst_time", bus.time_o, 28'd0);
        chk("rst_flags", {bus.stopped_o, bus.false_o, bus.timeout_o}, 6'd0);
        chk("rst_winner", {bus.winner_vld_o, bus.winner_o}, 4'd0);
        chk("rst_best", bus.best_o, 14'h3FFF);

        // best-time rounds: winners 9, 4, 12
        start_round();
        wait_run(1'b1);
        to_ms(9);
        pulse_stop(2'b01);
        chk("a_state", bus.state_o, 2'd2);
        chk("a_stopped", bus.stopped_o, 2'b01);
        to_ms(11);
        pulse_stop(2'b10);
        chk("a_done", bus.state_o, 2'd3);
        chk("a_time", bus.time_o, pk(11, 9));
        chk("a_win", {bus.winner_vld_o, bus.winner_o}, 4'b1000);
        step();
        step();
        chk("a_best", bus.best_o, exp_best(9));
        pulse_clear();

        start_round();
        wait_run(1'b1);
        to_ms(4);
        pulse_stop(2'b10);
        to_ms(6);
        pulse_stop(2'b01);
        chk("b_time", bus.time_o, pk(4, 6));
        chk("b_win", {bus.winner_vld_o, bus.winner_o}, 4'b1001);
        step();
        step();
        chk("b_best", bus.best_o, exp_best(4));
        pulse_clear();

        start_round();
        wait_run(1'b1);
        to_ms(12);
        pulse_stop(2'b01);
        to_ms(15);
        pulse_stop(2'b10);
        chk("c_win", {bus.winner_vld_o, bus.winner_o}, 4'b1000);
        step();
        step();
        chk("c_best", bus.best_o, exp_best(4));
        pulse_clear();
        chk("clr_time", bus.time_o, 28'd0);
        chk("clr_winner", {bus.winner_vld_o, bus.winner_o}, 4'd0);

        // player 1 at 5, player 0 at 7
        start_round();
        wait_run(1'b1);
        to_ms(5);
        pulse_stop(2'b10);
        chk("s1_run", bus.state_o, 2'd2);
        to_ms(7);
        pulse_stop(2'b01);
        chk("s1_done", bus.state_o, 2'd3);
        chk("s1_stim", bus.stim_o, 1'b0);
        chk("s1_time", bus.time_o, pk(5, 7));
        chk("s1_win", {bus.winner_vld_o, bus.winner_o}, 4'b1001);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("start_ignored", bus.state_o, 2'd3);
        pulse_clear();

        // false start by player 0
        start_round();
        pulse_stop(2'b01);
        chk("f_false", bus.false_o, 2'b01);
        chk("f_wait", bus.state_o, 2'd1);
        wait_run(1'b0);
        to_ms(4);
        pulse_stop(2'b11);
        chk("f_done", bus.state_o, 2'd3);
        chk("f_time", bus.time_o, pk(4, 0));
        chk("f_stopped", bus.stopped_o, 2'b10);
        chk("f_win", {bus.winner_vld_o, bus.winner_o}, 4'b1001);
        pulse_clear();
        chk("f_clr_false", bus.false_o, 2'b00);

        // both players jump the gun
        start_round();
        pulse_stop(2'b11);
        chk("bf_done", bus.state_o, 2'd3);
        chk("bf_false", bus.false_o, 2'b11);
        chk("bf_stim", bus.stim_o, 1'b0);
        chk("bf_vld", bus.winner_vld_o, 1'b0);
        pulse_clear();

        // nobody stops: timeout exactly at MAX_MS
        start_round();
        wait_run(1'b1);
        to_ms(MX);
        chk("to_still_run", bus.state_o, 2'd2);
        step();
        chk("to_done", bus.state_o, 2'd3);
        chk("to_flags", bus.timeout_o, 2'b11);
        chk("to_time", bus.time_o, pk(MX, MX));
        chk("to_vld", {bus.winner_vld_o, bus.stopped_o}, 3'b000);
        pulse_clear();
        chk("to_clr_flags", bus.timeout_o, 2'b00);

        // simultaneous stops
        start_round();
        wait_run(1'b1);
        to_ms(6);
        pulse_stop(2'b11);
        chk("sim_done", bus.state_o, 2'd3);
        chk("sim_time", bus.time_o, pk(6, 6));
        chk("sim_win", {bus.winner_vld_o, bus.winner_o}, 4'b1000);
        pulse_clear();

        // stop on the limit cycle counts as a valid stop
        start_round();
        wait_run(1'b1);
        to_ms(MX);
        pulse_stop(2'b01);
        chk("mx_done", bus.state_o, 2'd3);
        chk("mx_stopped", bus.stopped_o, 2'b01);
        chk("mx_tout", bus.timeout_o, 2'b10);
        chk("mx_time", bus.time_o, pk(MX, MX));
        chk("mx_win", {bus.winner_vld_o, bus.winner_o}, 4'b1000);
        step();
        step();
        chk("mx_best", bus.best_o, exp_best(4));
        pulse_clear();

        // clear beats a stop in the same cycle
        start_round();
        wait_run(1'b1);
        to_ms(3);
        bus.stop_i  = 2'b01;
        bus.clear_i = 1'b1;
        step();
        bus.stop_i  = '0;
        bus.clear_i = 1'b0;
        chk("cs_state", bus.state_o, 2'd0);
        chk("cs_stim", bus.stim_o, 1'b0);
        chk("cs_stopped", bus.stopped_o, 2'b00);
        chk("cs_time", bus.time_o, 28'd0);
        chk("cs_best", bus.best_o, exp_best(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
